// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, the 4 KB burst boundary and the burst-splitter state type.
package axi4_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_DONE  = 2'd2
  } a_state_e;

  // AxSIZE encoding for a bus of n bytes (n is a power of two).
  function automatic logic [2:0] arsize_from_bytes(input int unsigned n);
    for (int s = 0; s < 8; s++) begin
      if ((32'd1 << s) == n) return 3'(s);
    end
    return 3'd0;
  endfunction

endpackage

// File: rtl/axi4_read_burst_engine_if.sv
// Bus bundle of the read burst engine: command in, AR FIFO push, R FIFO pop, output stream.
// AXI4_READ_BURST_ENGINE_STATS_EN adds the statistics counters to the bundle.
interface axi4_read_burst_engine_if #(
  parameter int unsigned A = 32,
  parameter int unsigned N = 8,
  parameter int unsigned I = 1
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [A-1:0]     cmd_addr;
  logic [15:0]      cmd_beats;

  logic             ar_wr_full;
  logic             ar_wr_en;
  logic [A-1:0]     araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic [I-1:0]     arid;

  logic             r_rd_empty;
  logic             r_rd_en;
  logic [8*N-1:0]   rdata;
  logic [1:0]       rresp;
  logic             rlast;
  logic [I-1:0]     rid;

  logic             dout_valid;
  logic             dout_ready;
  logic [8*N-1:0]   dout_data;
  logic             dout_last;
  logic             dout_err;
  logic             busy;

`ifdef AXI4_READ_BURST_ENGINE_STATS_EN
  logic [31:0]      stat_bursts;
  logic [31:0]      stat_beats;
  logic [31:0]      stat_stall_cycles;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    output cmd_ready,
    input  ar_wr_full,
    output ar_wr_en, araddr, arlen, arsize, arburst, arid,
    input  r_rd_empty, rdata, rresp, rlast, rid,
    output r_rd_en,
    input  dout_ready,
    output dout_valid, dout_data, dout_last, dout_err, busy,
    output stat_bursts, stat_beats, stat_stall_cycles
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    input  cmd_ready,
    output ar_wr_full,
    input  ar_wr_en, araddr, arlen, arsize, arburst, arid,
    output r_rd_empty, rdata, rresp, rlast, rid,
    input  r_rd_en,
    output dout_ready,
    input  dout_valid, dout_data, dout_last, dout_err, busy,
    input  stat_bursts, stat_beats, stat_stall_cycles
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    output cmd_ready,
    input  ar_wr_full,
    output ar_wr_en, araddr, arlen, arsize, arburst, arid,
    input  r_rd_empty, rdata, rresp, rlast, rid,
    output r_rd_en,
    input  dout_ready,
    output dout_valid, dout_data, dout_last, dout_err, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    input  cmd_ready,
    output ar_wr_full,
    input  ar_wr_en, araddr, arlen, arsize, arburst, arid,
    output r_rd_empty, rdata, rresp, rlast, rid,
    input  r_rd_en,
    output dout_ready,
    input  dout_valid, dout_data, dout_last, dout_err, busy
  );
`endif

endinterface

// File: rtl/axi4_burst_splitter.sv
// Cuts one linear read command into INCR bursts limited by MAX_BURST and the 4 KB boundary.
module axi4_burst_splitter
  import axi4_pkg::*;
#(
  parameter int unsigned A         = 32,
  parameter int unsigned N         = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [A-1:0] addr_i,
  input  logic [15:0]  beats_i,
  input  logic         push_i,
  input  logic         done_i,
  output logic         issue_o,
  output logic [A-1:0] araddr_o,
  output logic [7:0]   arlen_o
);

  localparam int unsigned SZ   = int'(arsize_from_bytes(N));
  localparam logic [15:0] MAXB = 16'(MAX_BURST);

  // Beats that fit before the next 4 KB page, capped by MAX_BURST and what is left.
  function automatic logic [8:0] burst_beats(input logic [A-1:0] addr, input logic [15:0] rem);
    logic [15:0] room;
    logic [15:0] b;
    room = 16'((13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> SZ);
    b    = rem;
    if (MAXB < b) b = MAXB;
    if (room < b) b = room;
    return 9'(b);
  endfunction

  a_state_e     state_q;
  logic [A-1:0] addr_q;
  logic [15:0]  rem_q;
  logic [7:0]   len_q;

  logic [8:0]   bb_cur;
  logic [A-1:0] addr_nx;
  logic [15:0]  rem_nx;
  logic [7:0]   len_nx;

  always_comb begin
    bb_cur  = burst_beats(addr_q, rem_q);
    addr_nx = addr_q + (A'(bb_cur) << SZ);
    rem_nx  = rem_q - 16'(bb_cur);
    len_nx  = 8'(burst_beats(addr_nx, rem_nx) - 9'd1);
  end

  // Length of the next burst is precomputed on each push so arlen is a plain register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= A_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        A_IDLE: begin
          if (start_i) begin
            addr_q  <= addr_i;
            rem_q   <= beats_i;
            len_q   <= 8'(burst_beats(addr_i, beats_i) - 9'd1);
            state_q <= A_ISSUE;
          end
        end
        A_ISSUE: begin
          if (push_i) begin
            addr_q <= addr_nx;
            rem_q  <= rem_nx;
            if (rem_nx == 16'd0) begin
              state_q <= A_DONE;
            end else begin
              len_q <= len_nx;
            end
          end
        end
        A_DONE: begin
          if (done_i) state_q <= A_IDLE;
        end
        default: state_q <= A_IDLE;
      endcase
    end
  end

  assign issue_o  = (state_q == A_ISSUE);
  assign araddr_o = addr_q;
  assign arlen_o  = len_q;

endmodule

// File: rtl/axi4_read_burst_engine.sv
// Read-command front end on the FIFO side of an AXI4 master: issues bursts, drains R as a stream.
// AXI4_READ_BURST_ENGINE_STATS_EN adds free-running burst/beat/stall counters.
module axi4_read_burst_engine
  import axi4_pkg::*;
#(
  parameter int unsigned A         = 32,
  parameter int unsigned N         = 8,
  parameter int unsigned I         = 1,
  parameter int unsigned ARID      = 0,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi4_read_burst_engine_if.master bus
);

  localparam logic [2:0]   ARSIZE_V  = arsize_from_bytes(N);
  localparam logic [I-1:0] ARID_V    = I'(ARID);
  localparam logic [3:0]   MAX_OUT_V = 4'(MAX_OUT);

  logic        cmd_ready_q;
  logic        busy_q;
  logic        err_q;
  logic [15:0] beats_left_q;
  logic [3:0]  out_q;

  logic        accept;
  logic        issue;
  logic        push;
  logic        dv;
  logic        pop;
  logic        last_beat;
  logic        final_pop;
  logic        burst_drained;

  // Zero-length commands are never accepted.
  assign accept = bus.cmd_valid & cmd_ready_q & (bus.cmd_beats != 16'd0);

  axi4_burst_splitter #(
    .A         (A),
    .N         (N),
    .MAX_BURST (MAX_BURST)
  ) u_splitter (
    .clk_i    (aclk),
    .rst_ni   (aresetn),
    .start_i  (accept),
    .addr_i   (bus.cmd_addr),
    .beats_i  (bus.cmd_beats),
    .push_i   (push),
    .done_i   (final_pop),
    .issue_o  (issue),
    .araddr_o (bus.araddr),
    .arlen_o  (bus.arlen)
  );

  assign push          = issue & ~bus.ar_wr_full & (out_q < MAX_OUT_V);
  assign dv            = ~bus.r_rd_empty & busy_q;
  assign pop           = dv & bus.dout_ready;
  assign last_beat     = dv & (beats_left_q == 16'd1);
  assign final_pop     = pop & last_beat;
  assign burst_drained = pop & bus.rlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      beats_left_q <= '0;
    end else if (accept) begin
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      err_q        <= 1'b0;
      beats_left_q <= bus.cmd_beats;
    end else begin
      if (pop) begin
        beats_left_q <= beats_left_q - 16'd1;
        if (bus.rresp[1]) err_q <= 1'b1;
      end
      if (final_pop) begin
        busy_q      <= 1'b0;
        cmd_ready_q <= 1'b1;
      end
    end
  end

  // A push and a last-beat pop in the same cycle cancel out.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
    end else begin
      case ({push, burst_drained})
        2'b10:   out_q <= out_q + 4'd1;
        2'b01:   out_q <= out_q - 4'd1;
        default: out_q <= out_q;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.ar_wr_en   = push;
  assign bus.arsize     = ARSIZE_V;
  assign bus.arburst    = BURST_INCR;
  assign bus.arid       = ARID_V;
  assign bus.r_rd_en    = pop;
  assign bus.dout_valid = dv;
  assign bus.dout_data  = bus.rdata;
  assign bus.dout_last  = last_beat;
  assign bus.dout_err   = err_q;
  assign bus.busy       = busy_q;

`ifdef AXI4_READ_BURST_ENGINE_STATS_EN
  logic [31:0] stat_bursts_q;
  logic [31:0] stat_beats_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_bursts_q <= '0;
      stat_beats_q  <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_q + 32'(push);
      stat_beats_q  <= stat_beats_q + 32'(pop);
      stat_stall_q  <= stat_stall_q + 32'(busy_q & ~dv);
    end
  end

  assign bus.stat_bursts       = stat_bursts_q;
  assign bus.stat_beats        = stat_beats_q;
  assign bus.stat_stall_cycles = stat_stall_q;
`else
`endif

endmodule

// File: tb/tb_axi4_read_burst_engine.sv
// Scoreboard bench for axi4_read_burst_engine with a FIFO/slave model behind the AR and R FIFOs.
module tb_axi4_read_burst_engine;

  localparam int unsigned A         = 32;
  localparam int unsigned N         = 8;
  localparam int unsigned I         = 1;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned MAX_OUT   = 2;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi4_read_burst_engine_if #(.A(A), .N(N), .I(I)) bif ();

  axi4_read_burst_engine #(
    .A(A), .N(N), .I(I), .ARID(0), .MAX_BURST(MAX_BURST), .MAX_OUT(MAX_OUT)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bif)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic last; int err; } beat_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } r_t;

  ar_t   exp_ar[$];
  beat_t exp_dout[$];
  ar_t   pend[$];
  r_t    rfifo[$];

  int checks = 0;
  int errors = 0;
  int ar_seen = 0;
  int dout_seen = 0;
  int model_out = 0;
  int cyc = 0;
  bit slave_en = 1'b1;
  bit ready_mode = 1'b0;
  bit last_prev = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFF8;

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {~a, a};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic exp_burst(input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar.push_back(e);
  endtask

  // eb < 0: no error beat; otherwise beat eb carries SLVERR and dout_err is expected high after it.
  task automatic exp_beats(input logic [31:0] a, input int beats, input int eb);
    beat_t b;
    for (int i = 0; i < beats; i++) begin
      b.data = mem(a + 32'(i * 8));
      b.last = (i == beats - 1);
      if (eb < 0 || i < eb) b.err = 0;
      else if (i == eb)     b.err = 2;
      else                  b.err = 1;
      exp_dout.push_back(b);
    end
  endtask

  // Monitor: AR pushes and output beats are compared against the scoreboard queues.
  ar_t   mon_ar;
  beat_t mon_b;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (last_prev) begin
        chk("ready_after_last", 64'(bif.cmd_ready), 64'd1);
        chk("busy_after_last", 64'(bif.busy), 64'd0);
        last_prev = 1'b0;
      end
      if (bif.ar_wr_en && !bif.ar_wr_full) begin
        ar_seen++;
        chk("ar_out_limit", 64'(model_out < int'(MAX_OUT)), 64'd1);
        chk("arsize", 64'(bif.arsize), 64'd3);
        chk("arburst", 64'(bif.arburst), 64'd1);
        chk("arid", 64'(bif.arid), 64'd0);
        if (exp_ar.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ar_unexpected: got addr %0h len %0d expected no push", bif.araddr, bif.arlen);
        end else begin
          mon_ar = exp_ar.pop_front();
          chk("araddr", 64'(bif.araddr), 64'(mon_ar.addr));
          chk("arlen", 64'(bif.arlen), 64'(mon_ar.len));
        end
      end
      if (bif.dout_valid && bif.dout_ready) begin
        dout_seen++;
        chk("r_rd_en", 64'(bif.r_rd_en), 64'd1);
        if (exp_dout.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: got data %0h expected no beat", bif.dout_data);
        end else begin
          mon_b = exp_dout.pop_front();
          chk("dout_data", bif.dout_data, mon_b.data);
          chk("dout_last", 64'(bif.dout_last), 64'(mon_b.last));
          if (mon_b.err != 2) chk("dout_err", 64'(bif.dout_err), 64'(mon_b.err));
        end
        if (bif.dout_last) begin
          chk("ready_at_last", 64'(bif.cmd_ready), 64'd0);
          last_prev = 1'b1;
        end
      end
    end
  end

  // FIFO/slave model: AR entries become R beats one burst per cycle while slave_en is set.
  bit   env_push;
  bit   env_pop;
  ar_t  env_ar;
  ar_t  env_ar2;
  r_t   env_r;
  logic [31:0] env_a;
  always begin
    @(negedge aclk);
    env_push    = aresetn && bif.ar_wr_en && !bif.ar_wr_full;
    env_ar.addr = bif.araddr;
    env_ar.len  = bif.arlen;
    env_pop     = aresetn && bif.r_rd_en;
    @(posedge aclk);
    #1;
    cyc++;
    if (aresetn) begin
      if (env_push) begin
        pend.push_back(env_ar);
        model_out++;
      end
      if (env_pop && rfifo.size() > 0) begin
        env_r = rfifo.pop_front();
        if (env_r.last) model_out--;
      end
      if (slave_en && pend.size() > 0) begin
        env_ar2 = pend.pop_front();
        for (int k = 0; k <= int'(env_ar2.len); k++) begin
          env_a      = env_ar2.addr + 32'(k * 8);
          env_r.data = mem(env_a);
          env_r.resp = (env_a == err_addr) ? 2'b10 : 2'b00;
          env_r.last = (k == int'(env_ar2.len));
          rfifo.push_back(env_r);
        end
      end
    end
    bif.r_rd_empty = (rfifo.size() == 0);
    if (rfifo.size() > 0) begin
      bif.rdata = rfifo[0].data;
      bif.rresp = rfifo[0].resp;
      bif.rlast = rfifo[0].last;
    end else begin
      bif.rdata = '0;
      bif.rresp = 2'b00;
      bif.rlast = 1'b0;
    end
    bif.dout_ready = ready_mode ? (cyc % 3 != 0) : 1'b1;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bif.cmd_ready), 64'd1);
    chk({tag, "_ar_wr_en"}, 64'(bif.ar_wr_en), 64'd0);
    chk({tag, "_r_rd_en"}, 64'(bif.r_rd_en), 64'd0);
    chk({tag, "_dout_valid"}, 64'(bif.dout_valid), 64'd0);
    chk({tag, "_dout_last"}, 64'(bif.dout_last), 64'd0);
    chk({tag, "_dout_err"}, 64'(bif.dout_err), 64'd0);
    chk({tag, "_busy"}, 64'(bif.busy), 64'd0);
    chk({tag, "_araddr"}, 64'(bif.araddr), 64'd0);
    chk({tag, "_arlen"}, 64'(bif.arlen), 64'd0);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] beats);
    bit ok;
    ok = 1'b0;
    @(posedge aclk);
    #1;
    bif.cmd_addr  = a;
    bif.cmd_beats = beats;
    bif.cmd_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (bif.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    bif.cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1 within 100 cycles");
    end
    @(negedge aclk);
    chk("busy_after_accept", 64'(bif.busy), 64'd1);
    chk("ready_after_accept", 64'(bif.cmd_ready), 64'd0);
    chk("err_cleared_on_accept", 64'(bif.dout_err), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      #1;
      if (exp_dout.size() == 0 && exp_ar.size() == 0 && bif.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats %0d bursts pending expected 0", tag, exp_dout.size(), exp_ar.size());
    end
    chk({tag, "_busy_idle"}, 64'(bif.busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int base;
  bit seen3;
  initial begin
    aresetn        = 1'b0;
    bif.cmd_valid  = 1'b0;
    bif.cmd_addr   = '0;
    bif.cmd_beats  = '0;
    bif.ar_wr_full = 1'b0;
    bif.r_rd_empty = 1'b1;
    bif.rdata      = '0;
    bif.rresp      = 2'b00;
    bif.rlast      = 1'b0;
    bif.rid        = '0;
    bif.dout_ready = 1'b1;
    repeat (2) @(negedge aclk);
    check_reset_vals("reset");
    @(posedge aclk);
    #2;
    aresetn = 1'b1;

    // Linear 40 beats from 0 with consumer backpressure.
    ready_mode = 1'b1;
    exp_burst(32'h0000, 8'd15);
    exp_burst(32'h0080, 8'd15);
    exp_burst(32'h0100, 8'd7);
    exp_beats(32'h0000, 40, -1);
    send_cmd(32'h0000, 16'd40);
    wait_idle("lin40");
    ready_mode = 1'b0;

    // 4 KB boundary split.
    exp_burst(32'h0FC0, 8'd7);
    exp_burst(32'h1000, 8'd7);
    exp_beats(32'h0FC0, 16, -1);
    send_cmd(32'h0FC0, 16'd16);
    wait_idle("bound4k");

    // SLVERR on beat 7 of 20.
    err_addr = 32'h2038;
    exp_burst(32'h2000, 8'd15);
    exp_burst(32'h2080, 8'd3);
    exp_beats(32'h2000, 20, 7);
    send_cmd(32'h2000, 16'd20);
    wait_idle("err20");
    repeat (3) @(negedge aclk);
    chk("err_sticky_idle", 64'(bif.dout_err), 64'd1);

    // Outstanding limit with the R side held empty.
    slave_en = 1'b0;
    base = ar_seen;
    for (int k = 0; k < 5; k++) exp_burst(32'h3000 + 32'(k * 128), 8'd15);
    exp_beats(32'h3000, 80, -1);
    send_cmd(32'h3000, 16'd80);
    repeat (20) @(negedge aclk);
    #1;
    chk("maxout_pushes", 64'(ar_seen - base), 64'd2);
    chk("maxout_ar_blocked", 64'(bif.ar_wr_en), 64'd0);
    chk("maxout_no_dout", 64'(bif.dout_valid), 64'd0);
    slave_en = 1'b1;
    wait_idle("maxout");

    // AR FIFO full for 10 cycles after the first push.
    base = ar_seen;
    for (int k = 0; k < 4; k++) exp_burst(32'h4000 + 32'(k * 128), 8'd15);
    exp_beats(32'h4000, 64, -1);
    send_cmd(32'h4000, 16'd64);
    @(posedge aclk);
    #1;
    bif.ar_wr_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk("full_no_push", 64'(bif.ar_wr_en), 64'd0);
      chk("full_araddr_stable", 64'(bif.araddr), 64'h4080);
      chk("full_arlen_stable", 64'(bif.arlen), 64'd15);
    end
    #1;
    chk("full_push_count", 64'(ar_seen - base), 64'd1);
    @(posedge aclk);
    #1;
    bif.ar_wr_full = 1'b0;
    wait_idle("full");

    // Zero-beat command is ignored.
    @(posedge aclk);
    #1;
    bif.cmd_addr  = 32'h7000;
    bif.cmd_beats = 16'd0;
    bif.cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("zero_cmd_ready", 64'(bif.cmd_ready), 64'd1);
      chk("zero_busy", 64'(bif.busy), 64'd0);
    end
    @(posedge aclk);
    #1;
    bif.cmd_valid = 1'b0;

    // Reset after 3 delivered beats, then a fresh 4-beat command.
    base = dout_seen;
    exp_burst(32'h5000, 8'd15);
    exp_burst(32'h5080, 8'd15);
    exp_beats(32'h5000, 32, -1);
    send_cmd(32'h5000, 16'd32);
    seen3 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      #1;
      if (dout_seen - base >= 3) begin
        seen3 = 1'b1;
        break;
      end
    end
    chk("rst_mid_three_beats", 64'(seen3), 64'd1);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    exp_ar.delete();
    exp_dout.delete();
    pend.delete();
    rfifo.delete();
    model_out = 0;
    last_prev = 1'b0;
    bif.r_rd_empty = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    aresetn = 1'b1;

    exp_burst(32'h6000, 8'd3);
    exp_beats(32'h6000, 4, -1);
    send_cmd(32'h6000, 16'd4);
    wait_idle("post_rst");

    repeat (3) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_read_burst_engine.md
Name: axi4_read_burst_engine

Overview:
- Read-command front end that sits directly on the FIFO side of the AXI4 master read FIFO pair.
- Accepts one linear read command: start address plus beat count.
- Splits the command into INCR bursts that never cross a 4 KB boundary and pushes them into the AR write FIFO.
- Drains the R read FIFO and presents the data as a ready/valid stream with a command-level last flag and a sticky error flag.

Parameters:
- A, 32: address width.
- N, 8: data bus width in bytes; power of 2, 1..128.
- I, 1: ID width.
- ARID, 0: constant ID driven on every AR entry.
- MAX_BURST, 16: maximum beats per burst; power of 2, 1..256.
- MAX_OUT, 4: maximum bursts outstanding (issued, last beat not yet drained); 1..15.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  engine idle, command accepted on valid&ready.
- cmd_addr  in  A  start byte address; must be N-aligned.
- cmd_beats  in  16  total beats; 0 is illegal.
- ar_wr_full  in  1  AR FIFO full.
- ar_wr_en  out  1  push AR entry.
- araddr  out  A  burst address.
- arlen  out  8  beats-1.
- arsize  out  3  log2(N).
- arburst  out  2  constant 2'b01 (INCR).
- arid  out  I  constant ARID.
- r_rd_empty  in  1  R FIFO empty.
- r_rd_en  out  1  pop R entry.
- rdata  in  8N  R FIFO data.
- rresp  in  2  R FIFO response.
- rlast  in  1  R FIFO burst last.
- rid  in  I  R FIFO id (ignored).
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  consumer ready.
- dout_data  out  8N  beat data.
- dout_last  out  1  final beat of the command.
- dout_err  out  1  sticky, any non-OKAY rresp in the current command.
- busy  out  1  command in progress.

Behaviour:
- Reset:
  - Single clock aclk; asynchronous active-low reset aresetn.
  - In reset, all state clears: cmd_ready=1, ar_wr_en=0, r_rd_en=0, dout_valid=0, dout_last=0, dout_err=0, busy=0, araddr/arlen=0.
  - Reset mid-command abandons the command. Entries already in the FIFOs are the FIFO owner's concern; both FIFOs reset on the same aresetn.
- Command acceptance:
  - Accept on cmd_valid&cmd_ready.
  - Next cycle: busy=1, cmd_ready=0, dout_err cleared.
  - cmd_ready returns to 1 the cycle after the dout_last beat handshakes.
- AR issue side, states A_IDLE, A_ISSUE, A_DONE:
  - burst_beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / N).
  - ar_wr_en = (state==A_ISSUE) & ~ar_wr_full & (outstanding < MAX_OUT). It is combinational on the registered address/length; araddr and arlen are stable while in A_ISSUE.
  - On push: addr += burst_beats*N, remaining -= burst_beats, outstanding++.
  - When remaining reaches 0, go to A_DONE. Stay there until the command completes, then return to A_IDLE.
  - Back-to-back pushes are allowed every cycle.
- R drain side:
  - dout_valid = ~r_rd_empty & busy.
  - r_rd_en = dout_valid & dout_ready. Zero-latency pass-through: dout_data=rdata.
  - r_rd_en with rlast=1 decrements outstanding.
  - If the AR push and the R last-pop happen in the same cycle, outstanding stays unchanged.
  - dout_last = dout_valid & (beats_left==1). beats_left starts at cmd_beats and decrements per pop.
  - rlast is not used for dout_last.
  - dout_err sets on any popped beat with rresp[1]=1 and holds until the next command is accepted.
- Boundaries:
  - A burst ending exactly at a 4 KB boundary is legal.
  - Address wrap past 2^A is not checked.
  - cmd_beats=0 is ignored: no accept, and cmd_ready stays 1.

Optional Feature:
- Macro AXI4_READ_BURST_ENGINE_STATS_EN.
- Defined:
  - Adds ports stat_bursts (out, 32) and stat_beats (out, 32): free-running wrap-around counters of AR pushes and R pops. Cleared only by reset.
  - Adds stat_stall_cycles (out, 32): counts cycles where busy & ~dout_valid.
- Undefined: none of these ports or counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package axi4_pkg holds:
  - AXI burst/resp encodings: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - The 4 KB boundary constant.
  - A function that computes arsize from N.
- One natural sub-module, axi4_burst_splitter: owns addr, remaining, and the burst_beats computation, plus the A_* state machine.
- The R drain logic and outstanding counter stay in the top module.

Test Plan:
- addr 0x0000, beats 40, N=8, MAX_BURST=16:
  - AR entries: (0x000, arlen 15), (0x080, 15), (0x100, 7).
  - 40 dout beats; dout_last on beat 40 only.
- addr 0x0FC0, beats 16, N=8:
  - AR entries: (0x0FC0, arlen 7), (0x1000, arlen 7).
  - Neither burst crosses 0x1000.
- MAX_OUT=2, R FIFO held empty, 5-burst command: exactly 2 AR pushes, then ar_wr_en=0 until the first rlast is popped.
- ar_wr_full held high for 10 cycles mid-command: no push while full, araddr/arlen stable, resumes with no lost burst.
- One beat with rresp=2'b10 in a 20-beat command:
  - dout_err=1 from that beat until the next command is accepted.
  - All 20 beats are still delivered.
- aresetn asserted mid-command after 3 beats: outputs return to reset values immediately; a new 4-beat command afterwards completes normally.
